// File: rtl/seq_alu.sv
// seq_alu: multi-cycle integer ALU with valid/ready handshakes on both sides.
// Add, sub, compare, illegal and divide-by-zero finish in one cycle. Multiply
// (shift-add) and divide (restoring) take one iteration per clock for WIDTH clocks.
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operation request / block idle and able to accept
//   a, b                  operands (dividend/minuend, divisor/subtrahend)
//   instruction           [2:0] op, [3] isFloat, [4] isSigned
//   out_valid / out_ready result available / consumer takes result
//   s, ze, err            result, divide-by-zero flag, illegal-operation flag
module seq_alu #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             ze,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_a, r_b, r_acc, r_q, r_s;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg, r_ze, r_err;

    logic [2:0]         w_op;
    logic               w_sgn, w_ill, w_lt, w_gt, w_neg, w_last, w_fit, w_fze;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_fast, w_mul_acc, w_rem_next, w_q_next, w_res;
    logic [WIDTH:0]     w_shift;

    assign w_op     = instruction[2:0];
    assign w_sgn    = instruction[4];
    assign w_ill    = instruction[3] || w_op == 3'b010;
    assign w_lt     = w_sgn ? $signed(a) < $signed(b) : a < b;
    assign w_gt     = w_sgn ? $signed(a) > $signed(b) : a > b;
    // Signed mul/div run on magnitudes; the sign is reapplied to the final result.
    assign w_a_mag  = (w_sgn && a[WIDTH-1]) ? -a : a;
    assign w_b_mag  = (w_sgn && b[WIDTH-1]) ? -b : b;
    assign w_neg    = w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
    assign w_fze    = !w_ill && w_op == 3'b111 && b == '0;
    assign w_last   = r_cnt == CNT_W'(WIDTH - 1);

    // Shift-add step: r_a is the multiplicand shifted left, r_q the multiplier shifted right.
    assign w_mul_acc = r_acc + (r_q[0] ? r_a : '0);

    // Restoring step: r_acc is the partial remainder, r_q shifts dividend bits out
    // at the top and quotient bits in at the bottom.
    assign w_shift    = {r_acc, r_q[WIDTH-1]};
    assign w_fit      = w_shift >= {1'b0, r_b};
    assign w_rem_next = w_fit ? WIDTH'(w_shift - {1'b0, r_b}) : w_shift[WIDTH-1:0];
    assign w_q_next   = {r_q[WIDTH-2:0], w_fit};

    assign w_res = (r_state == MUL) ? w_mul_acc : w_q_next;

    always_comb begin
        w_fast = '0;
        if (!w_ill) begin
            case (w_op)
                3'b000:  w_fast = a + b;
                3'b001:  w_fast = a - b;
                3'b100:  w_fast = {{(WIDTH-1){1'b0}}, w_lt};
                3'b101:  w_fast = {{(WIDTH-1){1'b0}}, a == b};
                3'b110:  w_fast = {{(WIDTH-1){1'b0}}, w_gt};
                3'b111:  w_fast = '1;
                default: w_fast = '0;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (in_valid)
                      w_next = w_ill ? DONE :
                               w_op == 3'b011 ? MUL :
                               (w_op == 3'b111 && b != '0) ? DIV : DONE;
            MUL:  if (w_last) w_next = DONE;
            DIV:  if (w_last) w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_s     <= '0;
            r_ze    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: if (in_valid) begin
                    r_a   <= w_a_mag;
                    r_b   <= w_b_mag;
                    r_q   <= (w_op == 3'b011) ? w_b_mag : w_a_mag;
                    r_acc <= '0;
                    r_cnt <= '0;
                    r_neg <= w_neg;
                    r_s   <= w_fast;
                    r_ze  <= w_fze;
                    r_err <= w_ill;
                end
                MUL: begin
                    r_acc <= w_mul_acc;
                    r_a   <= r_a << 1;
                    r_q   <= r_q >> 1;
                    r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                    if (w_last) r_s <= r_neg ? -w_res : w_res;
                end
                DIV: begin
                    r_acc <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                    if (w_last) r_s <= r_neg ? -w_res : w_res;
                end
                DONE: ;
            endcase
        end
    end

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign s         = r_s;
    assign ze        = r_ze;
    assign err       = r_err;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;
    localparam int W = 32;

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid, ze, err;
    logic [W-1:0] a = '0, b = '0, s;
    logic [4:0]   instruction = '0;
    logic [W-1:0] last_s;
    int           checks = 0, failures = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .instruction(instruction), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .ze(ze), .err(err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [4:0] ins, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rs, output logic rze, output logic rerr);
        longint sx, sy;
        logic [2:0] op;
        op = ins[2:0];
        sx = ins[4] ? longint'($signed(x)) : longint'({32'b0, x});
        sy = ins[4] ? longint'($signed(y)) : longint'({32'b0, y});
        rs = '0; rze = 1'b0; rerr = 1'b0;
        if (ins[3] || op == 3'd2) rerr = 1'b1;
        else case (op)
            3'd0: rs = x + y;
            3'd1: rs = x - y;
            3'd3: rs = 32'(sx * sy);
            3'd4: rs = 32'(sx < sy);
            3'd5: rs = 32'(x == y);
            3'd6: rs = 32'(sx > sy);
            default: if (y == 0) begin rs = '1; rze = 1'b1; end
                     else rs = 32'(sx / sy);
        endcase
    endfunction

    task automatic do_op(input logic [4:0] ins, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] es;
        logic eze, eerr;
        int lat, n;
        model(ins, x, y, es, eze, eerr);
        lat = (!eerr && (ins[2:0] == 3'd3 || (ins[2:0] == 3'd7 && y != 0))) ? W : 0;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; a = x; b = y; instruction = ins;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; instruction = 5'($urandom);
        n = 0;
        while (!out_valid && n < 3 * W) begin
            check("busy_in_ready", in_ready, 0);
            @(posedge clk); #1;
            n++;
        end
        check("out_valid", out_valid, 1);
        check("latency", n, lat);
        check("s", s, es);
        check("ze", ze, eze);
        check("err", err, eerr);
        last_s = s;
    endtask

    task automatic finish_op;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("done_out_valid", out_valid, 0);
        check("ret_in_ready", in_ready, 1);
    endtask

    initial begin
        logic seen;
        logic [31:0] spec [5];
        logic [31:0] x, y;
        logic [4:0] ins;
        int hold;
        spec = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_ze", ze, 0);
        check("rst_err", err, 0);
        @(negedge clk) rst_n = 1'b1;

        do_op(5'b00000, 32'hFFFF_FFFF, 32'h1);
        check("add_wrap", last_s, 0);
        finish_op();
        do_op(5'b10011, 32'hFFFF_FFF9, 32'd6);
        check("smul", last_s, 32'hFFFF_FFD6);
        finish_op();
        do_op(5'b10111, 32'hFFFF_FF9C, 32'd7);
        check("sdiv", last_s, 32'hFFFF_FFF2);
        finish_op();
        do_op(5'b00111, 32'd100, 32'd7);
        check("udiv", last_s, 32'd14);
        finish_op();
        do_op(5'b10111, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_mostneg", last_s, 32'h8000_0000);
        finish_op();
        do_op(5'b10111, 32'd5, 32'd0);
        check("sdiv0_ze", ze, 1);
        finish_op();
        do_op(5'b00111, 32'd5, 32'd0);
        check("udiv0_s", last_s, 32'hFFFF_FFFF);
        finish_op();
        do_op(5'b00000, 32'd3, 32'd4);
        check("add_after_div0_ze", ze, 0);
        finish_op();
        do_op(5'b10110, 32'd1, 32'hFFFF_FFFF);
        check("sgt", last_s, 1);
        finish_op();
        do_op(5'b00110, 32'd1, 32'hFFFF_FFFF);
        check("ugt", last_s, 0);
        finish_op();
        do_op(5'b00010, 32'd9, 32'd9);
        check("illegal_op_err", err, 1);
        finish_op();
        do_op(5'b01000, 32'd9, 32'd9);
        check("float_err", err, 1);
        finish_op();

        out_ready = 1'b0;
        do_op(5'b10011, 32'hFFFF_FFF9, 32'd6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = $urandom; b = $urandom; instruction = 5'($urandom);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("bp_s", s, 32'hFFFF_FFD6);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        finish_op();
        @(posedge clk); #1;
        check("bp_no_accept", out_valid, 0);

        @(negedge clk);
        in_valid = 1'b1; a = 32'd1000; b = 32'd7; instruction = 5'b00111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", seen, 0);

        for (int i = 0; i < 60; i++) begin
            ins = 5'($urandom);
            if ($urandom_range(0, 4) != 0) begin
                ins[3] = 1'b0;
                if (ins[2:0] == 3'd2) ins[2:0] = 3'd3;
            end
            x = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) y = 32'($urandom_range(0, 20));
            out_ready = 1'($urandom_range(0, 1));
            do_op(ins, x, y);
            hold = $urandom_range(0, 3);
            for (int j = 0; j < hold && !out_ready; j++) begin
                @(posedge clk); #1;
                check("rand_hold_s", s, last_s);
            end
            finish_op();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
